text_console_writer: RTL and testbench

- Upstream producer of the text-mode display memory: it fills the memory that the text renderer reads.
- Accepts a byte stream from the CPU/bus side over a valid/ready handshake and interprets control characters.
- Maintains a hardware cursor and writes ASCII codes into the 40x30 character buffer through the memory's write port.
- Buffer address = col + row*40. Performs screen clear and one-line scroll by copying memory contents.

---
 rtl/text_pkg.sv | 41 ++++
 rtl/text_cursor.sv | 64 ++++++
 rtl/text_console_writer.sv | 173 +++++++++++++++++
 tb/tb_text_console_writer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared text-mode definitions: screen geometry, control codes and the
// row-base address formula used by both this writer and the renderer.
package text_pkg;
    localparam int TXT_COLS   = 40;
    localparam int TXT_ROWS   = 30;
    localparam int TXT_ADDR_W = 12;
    localparam logic [7:0] TXT_BLANK = 8'h20;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        CLEAR_ALL,
        IDLE,
        WRITE,
        SCROLL_RD,
        SCROLL_WR,
        CLEAR_ROW
    } state_t;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADV,
        CUR_CR,
        CUR_LF,
        CUR_BS,
        CUR_HOME
    } cur_cmd_t;

    // 40 columns avoids a multiplier: row*40 = row*32 + row*8
    function automatic logic [TXT_ADDR_W-1:0] row_base(input logic [4:0] row, input int cols);
        logic [TXT_ADDR_W-1:0] r;
        r = TXT_ADDR_W'(row);
        if (cols == 40) begin
            return (r << 5) + (r << 3);
        end
        return r * TXT_ADDR_W'(cols);
    endfunction
endpackage

// File: rtl/text_cursor.sv
// Cursor position registers; reports when a line advance falls off the
// bottom row so the writer can scroll instead.
module text_cursor
    import text_pkg::*;
#(
    parameter int COLS = TXT_COLS,
    parameter int ROWS = TXT_ROWS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  cur_cmd_t   cmd,
    output logic [5:0] col,
    output logic [4:0] row,
    output logic       scroll_req
);
    logic [5:0] col_nxt;
    logic [4:0] row_nxt;
    logic       wrap;

    always_comb begin
        col_nxt    = col;
        row_nxt    = row;
        wrap       = 1'b0;
        scroll_req = 1'b0;
        case (cmd)
            CUR_ADV: begin
                if (col == 6'(COLS - 1)) begin
                    col_nxt = '0;
                    wrap    = 1'b1;
                end else begin
                    col_nxt = col + 6'd1;
                end
            end
            CUR_CR: col_nxt = '0;
            CUR_LF: begin
                col_nxt = '0;
                wrap    = 1'b1;
            end
            CUR_BS: begin
                if (col != '0) col_nxt = col - 6'd1;
            end
            CUR_HOME: begin
                col_nxt = '0;
                row_nxt = '0;
            end
            default: ;
        endcase
        // The bottom row stays put; the screen contents move up instead
        if (wrap) begin
            if (row == 5'(ROWS - 1)) scroll_req = 1'b1;
            else                     row_nxt    = row + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= col_nxt;
            row <= row_nxt;
        end
    end
endmodule

// File: rtl/text_console_writer.sv
// Byte-stream console writer: interprets control codes, writes characters
// into the 40x30 text buffer, and performs full clears and one-line scrolls.
//   state     | meaning
//   CLEAR_ALL | blank every cell, one write per cycle, then home cursor
//   IDLE      | ready for one byte
//   WRITE     | act on latched byte (write and/or move cursor)
//   SCROLL_RD | read source cell src
//   SCROLL_WR | write that data to src-COLS
//   CLEAR_ROW | blank the bottom row
module text_console_writer
    import text_pkg::*;
#(
    parameter int COLS   = TXT_COLS,
    parameter int ROWS   = TXT_ROWS,
    parameter int ADDR_W = TXT_ADDR_W,
    parameter logic [7:0] BLANK = TXT_BLANK
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [7:0]        char_dat,
    input  logic              char_valid,
    output logic              char_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'((ROWS - 1) * COLS);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [7:0]        byte_q;
    cur_cmd_t          cmd;
    logic              scroll_req;
    logic [ADDR_W-1:0] cur_addr;
    logic              we_c, re_c, ready_c, busy_c;
    logic [ADDR_W-1:0] addr_c;
    logic [7:0]        wdata_c;

    text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk        (clk),
        .rst_n      (clr),
        .cmd        (cmd),
        .col        (cursor_col),
        .row        (cursor_row),
        .scroll_req (scroll_req)
    );

    assign cur_addr = ADDR_W'(row_base(cursor_row, COLS)) + ADDR_W'(cursor_col);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cmd       = CUR_NONE;
        we_c      = 1'b0;
        re_c      = 1'b0;
        ready_c   = 1'b0;
        busy_c    = 1'b0;
        addr_c    = '0;
        wdata_c   = '0;
        case (state)
            CLEAR_ALL: begin
                busy_c  = 1'b1;
                we_c    = 1'b1;
                addr_c  = cnt;
                wdata_c = BLANK;
                if (cnt == LAST_ADDR) begin
                    cnt_nxt   = '0;
                    cmd       = CUR_HOME;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            IDLE: begin
                ready_c = 1'b1;
                if (char_valid) state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = IDLE;
                if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
                    we_c    = 1'b1;
                    addr_c  = cur_addr;
                    wdata_c = byte_q;
                    cmd     = CUR_ADV;
                end else begin
                    case (byte_q)
                        CH_CR: cmd = CUR_CR;
                        CH_LF: cmd = CUR_LF;
                        CH_BS: begin
                            if (cursor_col != '0) begin
                                we_c    = 1'b1;
                                addr_c  = cur_addr - ADDR_W'(1);
                                wdata_c = BLANK;
                                cmd     = CUR_BS;
                            end
                        end
                        CH_FF: begin
                            state_nxt = CLEAR_ALL;
                            cnt_nxt   = '0;
                        end
                        default: ;
                    endcase
                end
                if (scroll_req) begin
                    state_nxt = SCROLL_RD;
                    cnt_nxt   = COLS_A;
                end
            end
            SCROLL_RD: begin
                busy_c    = 1'b1;
                re_c      = 1'b1;
                addr_c    = cnt;
                state_nxt = SCROLL_WR;
            end
            SCROLL_WR: begin
                busy_c  = 1'b1;
                we_c    = 1'b1;
                addr_c  = cnt - COLS_A;
                wdata_c = mem_rdata;
                if (cnt == LAST_ADDR) begin
                    cnt_nxt   = LAST_ROW;
                    state_nxt = CLEAR_ROW;
                end else begin
                    cnt_nxt   = cnt + ADDR_W'(1);
                    state_nxt = SCROLL_RD;
                end
            end
            CLEAR_ROW: begin
                busy_c  = 1'b1;
                we_c    = 1'b1;
                addr_c  = cnt;
                wdata_c = BLANK;
                if (cnt == LAST_ADDR) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = CLEAR_ALL;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= CLEAR_ALL;
            cnt    <= '0;
            byte_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && char_valid) byte_q <= char_dat;
        end
    end

    // Outputs are forced low for the whole time clr is held
    assign mem_we     = clr & we_c;
    assign mem_re     = clr & re_c;
    assign char_ready = clr & ready_c;
    assign busy       = clr & busy_c;
    assign mem_addr   = clr ? addr_c  : '0;
    assign mem_wdata  = clr ? wdata_c : '0;
endmodule

// File: tb/tb_text_console_writer.sv
// Randomized scoreboard bench for text_console_writer with a screen-level
// reference model and a behavioural display memory.
module tb_text_console_writer;
    localparam int NC = 40;
    localparam int NR = 30;
    localparam int N  = NC * NR;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  char_dat = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    logic [7:0]  tbmem [N];

    always #5 clk = ~clk;

    text_console_writer dut (
        .clk        (clk),
        .clr        (clr),
        .char_dat   (char_dat),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always @(posedge clk) begin
        if (mem_we && int'(mem_addr) < N) tbmem[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_re && int'(mem_addr) < N) ? tbmem[mem_addr] : 8'h00;
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_w[$];
    int  exp_r[$];
    logic [7:0] scr [NR][NC];
    int  mcol = 0;
    int  mrow = 0;

    task automatic check(input bit ok, input string name, input string act, input string req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, act, req);
        end
    endtask

    function automatic void push_w(input int a, input int d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_w.push_back(e);
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) scr[r][c] = 8'h20;
        for (int a = 0; a < N; a++) push_w(a, 8'h20);
        mcol = 0;
        mrow = 0;
    endfunction

    function automatic void model_newline();
        if (mrow < NR - 1) begin
            mrow++;
        end else begin
            for (int src = NC; src < N; src++) begin
                exp_r.push_back(src);
                push_w(src - NC, int'(scr[src / NC][src % NC]));
            end
            for (int r = 0; r < NR - 1; r++)
                for (int c = 0; c < NC; c++) scr[r][c] = scr[r + 1][c];
            for (int c = 0; c < NC; c++) begin
                scr[NR - 1][c] = 8'h20;
                push_w((NR - 1) * NC + c, 8'h20);
            end
        end
    endfunction

    function automatic void model_apply(input logic [7:0] b, output bit wr, output int wa);
        wr = 1'b0;
        wa = mrow * NC + mcol;
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_w(wa, int'(b));
            scr[mrow][mcol] = b;
            wr = 1'b1;
            mcol++;
            if (mcol == NC) begin
                mcol = 0;
                model_newline();
            end
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h0A) begin
            mcol = 0;
            model_newline();
        end else if (b == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                wa = mrow * NC + mcol;
                push_w(wa, 8'h20);
                scr[mrow][mcol] = 8'h20;
                wr = 1'b1;
            end
        end else if (b == 8'h0C) begin
            model_clear();
        end
    endfunction

    always @(negedge clk) begin : monitor
        wr_t e;
        int  ra;
        if (clr) begin
            check(!(mem_we && mem_re), "strobe_exclusive", "we&re", "not both");
            if (mem_we) begin
                if (exp_w.size() == 0) begin
                    check(1'b0, "unexpected_write",
                          $sformatf("addr=%0d data=%02h", mem_addr, mem_wdata), "no write");
                end else begin
                    e = exp_w.pop_front();
                    check(int'(mem_addr) == e.addr && int'(mem_wdata) == e.data, "write",
                          $sformatf("addr=%0d data=%02h", mem_addr, mem_wdata),
                          $sformatf("addr=%0d data=%02h", e.addr, e.data));
                end
            end
            if (mem_re) begin
                check(busy, "busy_during_scroll", $sformatf("%0b", busy), "1");
                if (exp_r.size() == 0) begin
                    check(1'b0, "unexpected_read", $sformatf("addr=%0d", mem_addr), "no read");
                end else begin
                    ra = exp_r.pop_front();
                    check(int'(mem_addr) == ra, "read",
                          $sformatf("addr=%0d", mem_addr), $sformatf("addr=%0d", ra));
                end
            end
            if (!mem_we && !mem_re)
                check(mem_addr == 12'd0 && mem_wdata == 8'd0, "bus_idle_zero",
                      $sformatf("addr=%0d data=%02h", mem_addr, mem_wdata), "addr=0 data=00");
        end
    end

    task automatic check_cursor(input string name);
        check(int'(cursor_col) == mcol && int'(cursor_row) == mrow, name,
              $sformatf("(%0d,%0d)", cursor_col, cursor_row), $sformatf("(%0d,%0d)", mcol, mrow));
    endtask

    task automatic check_reset_outputs(input string name);
        check(!mem_we && !mem_re && mem_addr == 0 && mem_wdata == 0 && !char_ready && !busy
              && cursor_col == 0 && cursor_row == 0, name,
              $sformatf("we=%0b re=%0b addr=%0d wd=%02h rdy=%0b busy=%0b cur=(%0d,%0d)",
                        mem_we, mem_re, mem_addr, mem_wdata, char_ready, busy, cursor_col, cursor_row),
              "all zero");
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) check(1'b0, "ready_timeout", "not ready", "ready within 5000 cycles");
    endtask

    task automatic release_and_clear(input string name);
        int n = 0;
        @(posedge clk);
        #2 clr = 1'b1;
        @(negedge clk);
        while (!char_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check(n == N, name, $sformatf("%0d busy cycles", n), $sformatf("%0d busy cycles", N));
        check_cursor({name, "_cursor"});
    endtask

    task automatic send(input logic [7:0] b, input bit wait_done, output int acc_wait);
        bit wr;
        int wa;
        int n = 0;
        model_apply(b, wr, wa);
        @(negedge clk);
        char_dat   = b;
        char_valid = 1'b1;
        while (!char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) check(1'b0, "accept_timeout", "not ready", "ready within 5000 cycles");
        acc_wait = n;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_dat   = 8'($urandom);
        if (wr) begin
            @(negedge clk);
            check(mem_we && int'(mem_addr) == wa, "write_latency",
                  $sformatf("we=%0b addr=%0d", mem_we, mem_addr), $sformatf("we=1 addr=%0d", wa));
        end
        if (wait_done) begin
            wait_ready();
            check_cursor($sformatf("cursor_after_%02h", b));
        end
    endtask

    initial begin : stim
        int w;
        int r;
        int bad;
        int first_bad;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset_state");
        model_clear();
        release_and_clear("initial_clear");

        send(8'h41, 1'b1, w);
        send(8'h0D, 1'b1, w);
        for (int i = 0; i < NC; i++) begin
            send(8'($urandom_range(8'h21, 8'h7E)), i == NC - 1, w);
            if (i > 0) check(w == 0, "throughput", $sformatf("%0d wait", w), "0 wait");
        end
        send(8'h0D, 1'b1, w);
        send(8'h0A, 1'b1, w);
        send(8'h42, 1'b1, w);

        send(8'h0C, 1'b1, w);
        for (int i = 0; i < 3; i++) send(8'h0A, 1'b1, w);
        send(8'h08, 1'b1, w);
        for (int i = 0; i < 7; i++) send(8'h61 + 8'(i), 1'b1, w);
        send(8'h08, 1'b1, w);

        while (mrow < NR - 1) send(8'h0A, 1'b1, w);
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 1'b1, w);
        send(8'h0A, 1'b0, w);
        send(8'h5A, 1'b1, w);
        check(w == 1 + 2 * (N - NC) + NC, "scroll_busy_len",
              $sformatf("%0d wait", w), $sformatf("%0d wait", 1 + 2 * (N - NC) + NC));

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 80) b = 8'h0A;
            else if (r < 85) b = 8'h0D;
            else if (r < 92) b = 8'h08;
            else if (r < 94) b = 8'h0C;
            else begin
                b = 8'($urandom);
                if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D)
                    b = 8'h01;
            end
            send(b, $urandom_range(0, 3) != 0, w);
        end
        wait_ready();

        while (mrow < NR - 1) send(8'h0A, 1'b1, w);
        send(8'h0A, 1'b0, w);
        repeat (1000) @(negedge clk);
        @(posedge clk);
        #1 clr = 1'b0;
        #1 check_reset_outputs("reset_mid_scroll");
        exp_w.delete();
        exp_r.delete();
        model_clear();
        repeat (3) @(posedge clk);
        release_and_clear("restart_clear");
        send(8'h51, 1'b1, w);

        wait_ready();
        @(negedge clk);
        bad = 0;
        first_bad = -1;
        for (int a = 0; a < N; a++) begin
            if (tbmem[a] !== scr[a / NC][a % NC]) begin
                bad++;
                if (first_bad < 0) first_bad = a;
            end
        end
        check(bad == 0, "screen_contents", $sformatf("%0d bad cells, first at %0d", bad, first_bad),
              "0 bad cells");
        check(exp_w.size() == 0 && exp_r.size() == 0, "queues_drained",
              $sformatf("w=%0d r=%0d", exp_w.size(), exp_r.size()), "w=0 r=0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
